// File: rtl/carry_byte_resolver.sv
// carry_byte_resolver: turns coder pre-bytes into final bytes, holding back 0xFF runs until the carry is known.
// Latency: 1 cycle from accept to out_valid; each run byte takes one out_ready transfer. Optional counter: CARRY_BYTE_STATS_EN.
// Backpressure: in_ready is low while emitting; out_valid/out_byte are held while out_ready is low.
module carry_byte_resolver #(
  parameter int GENERAL_RUN_WIDTH = 8
) (
  input  logic       general_clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [8:0] in_byte,
  output logic       in_ready,
  input  logic       flush,
  output logic       out_valid,
  output logic [7:0] out_byte,
  input  logic       out_ready,
  output logic       flush_done,
  output logic       err_overflow,
  output logic       err_orphan_carry
`ifdef CARRY_BYTE_STATS_EN
  ,
  output logic [31:0] byte_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    EMIT_P,
    EMIT_RUN,
    FLUSH_P,
    FLUSH_RUN
  } state_t;

  localparam logic [GENERAL_RUN_WIDTH-1:0] RUN_MAX = '1;
  localparam logic [GENERAL_RUN_WIDTH-1:0] RUN_ONE = GENERAL_RUN_WIDTH'(1);

  state_t                       state;
  logic [7:0]                   pend_byte;
  logic [7:0]                   next_byte;
  logic                         pend_valid;
  logic [GENERAL_RUN_WIDTH-1:0] run_cnt;
  logic                         carry;

  always_comb begin
    in_ready = (state == IDLE) || (state == HOLD);
  end

  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      pend_byte        <= 8'h00;
      next_byte        <= 8'h00;
      pend_valid       <= 1'b0;
      run_cnt          <= '0;
      carry            <= 1'b0;
      out_valid        <= 1'b0;
      out_byte         <= 8'h00;
      flush_done       <= 1'b0;
      err_overflow     <= 1'b0;
      err_orphan_carry <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            pend_byte  <= in_byte[7:0];
            pend_valid <= 1'b1;
            run_cnt    <= '0;
            state      <= HOLD;
            if (in_byte[8] && !pend_valid) begin
              err_orphan_carry <= 1'b1;
            end
          end else if (flush) begin
            flush_done <= 1'b1;
          end
        end

        HOLD: begin
          if (in_valid) begin
            if (in_byte == 9'h0FF) begin
              // A saturated run cannot grow; the extra 0xFF is dropped.
              if (run_cnt == RUN_MAX) begin
                err_overflow <= 1'b1;
              end else begin
                run_cnt <= run_cnt + RUN_ONE;
              end
            end else begin
              carry     <= in_byte[8];
              next_byte <= in_byte[7:0];
              out_byte  <= pend_byte + {7'd0, in_byte[8]};
              out_valid <= 1'b1;
              state     <= EMIT_P;
            end
          end else if (flush) begin
            out_byte  <= pend_byte;
            out_valid <= 1'b1;
            state     <= FLUSH_P;
          end
        end

        EMIT_P: begin
          if (out_ready) begin
            if (run_cnt != '0) begin
              out_byte <= carry ? 8'h00 : 8'hFF;
              state    <= EMIT_RUN;
            end else begin
              pend_byte <= next_byte;
              run_cnt   <= '0;
              out_valid <= 1'b0;
              state     <= HOLD;
            end
          end
        end

        EMIT_RUN: begin
          if (out_ready) begin
            run_cnt <= run_cnt - RUN_ONE;
            if (run_cnt == RUN_ONE) begin
              pend_byte <= next_byte;
              out_valid <= 1'b0;
              state     <= HOLD;
            end
          end
        end

        FLUSH_P: begin
          if (out_ready) begin
            if (run_cnt != '0) begin
              out_byte <= 8'hFF;
              state    <= FLUSH_RUN;
            end else begin
              out_valid  <= 1'b0;
              pend_valid <= 1'b0;
              flush_done <= 1'b1;
              state      <= IDLE;
            end
          end
        end

        FLUSH_RUN: begin
          if (out_ready) begin
            run_cnt <= run_cnt - RUN_ONE;
            if (run_cnt == RUN_ONE) begin
              out_valid  <= 1'b0;
              pend_valid <= 1'b0;
              flush_done <= 1'b1;
              state      <= IDLE;
            end
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CARRY_BYTE_STATS_EN
  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      byte_count <= 32'd0;
    end else if (out_valid && out_ready && (byte_count != 32'hFFFF_FFFF)) begin
      byte_count <= byte_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_carry_byte_resolver.sv
// Bench for carry_byte_resolver: directed scenarios plus randomized traffic against a byte-level carry model.
module tb_carry_byte_resolver;

  logic       general_clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [8:0] in_byte = 9'd0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready = 1'b1;
  logic       flush_done;
  logic       err_overflow;
  logic       err_orphan_carry;
`ifdef CARRY_BYTE_STATS_EN
  logic [31:0] byte_count;
`endif

  carry_byte_resolver #(.GENERAL_RUN_WIDTH(8)) dut (
    .general_clk      (general_clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_byte          (in_byte),
    .in_ready         (in_ready),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_byte         (out_byte),
    .out_ready        (out_ready),
    .flush_done       (flush_done),
    .err_overflow     (err_overflow),
    .err_orphan_carry (err_orphan_carry)
`ifdef CARRY_BYTE_STATS_EN
    ,
    .byte_count       (byte_count)
`endif
  );

  always #5 general_clk = ~general_clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int fd_cnt = 0;
  int exp_fd = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by the test

  // Reference model: the byte stream the coder means, tracked as pending byte + count of deferred 0xFF.
  bit         m_pend;
  logic [7:0] m_p;
  int         m_run;
  bit         m_ovf;
  bit         m_orph;

  function automatic void model_push(input logic [8:0] b);
    int c;
    if (!m_pend) begin
      m_p = b[7:0];
      m_pend = 1'b1;
      m_run = 0;
      if (b[8]) m_orph = 1'b1;
    end else if (b == 9'h0FF) begin
      if (m_run == 255) m_ovf = 1'b1;
      else m_run = m_run + 1;
    end else begin
      c = int'(b[8]);
      exp_q.push_back(8'((int'(m_p) + c) % 256));
      for (int i = 0; i < m_run; i++) exp_q.push_back(c ? 8'h00 : 8'hFF);
      m_p = b[7:0];
      m_run = 0;
    end
  endfunction

  function automatic void model_flush();
    if (m_pend) begin
      exp_q.push_back(m_p);
      for (int i = 0; i < m_run; i++) exp_q.push_back(8'hFF);
    end
    m_pend = 1'b0;
    m_run = 0;
    exp_fd = exp_fd + 1;
  endfunction

  always @(negedge general_clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back(out_byte);
    if (!reset && flush_done) fd_cnt = fd_cnt + 1;
  end

  initial begin
    forever begin
      @(posedge general_clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge general_clk);
    @(negedge general_clk);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    fd_cnt = 0;
    exp_fd = 0;
    m_pend = 1'b0;
    m_p = 8'h00;
    m_run = 0;
    m_ovf = 1'b0;
    m_orph = 1'b0;
    @(posedge general_clk);
    #1;
  endtask

  task automatic send(input logic [8:0] b, input bit wf);
    int n;
    n = 0;
    while (!in_ready && n < 1000) begin
      @(posedge general_clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_wait in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_byte = b;
    flush = wf;
    model_push(b);
    @(posedge general_clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_flush();
    int n;
    n = 0;
    while (!in_ready && n < 1000) begin
      @(posedge general_clk);
      #1;
      n++;
    end
    flush = 1'b1;
    model_flush();
    @(posedge general_clk);
    #1;
    flush = 1'b0;
    n = 0;
    while (fd_cnt < exp_fd && n < 2000) begin
      @(posedge general_clk);
      #1;
      n++;
    end
    if (fd_cnt < exp_fd) begin
      errors++;
      checks++;
      $display("FAIL flush_wait flush_done count=%0d required %0d", fd_cnt, exp_fd);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b required 0", out_valid); end
    checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL reset_out_byte got %02h required 00", out_byte); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b required 1", in_ready); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %0b required 0", flush_done); end
    checks++; if ({err_overflow, err_orphan_carry} !== 2'b00) begin errors++; $display("FAIL reset_errs got %02b required 00", {err_overflow, err_orphan_carry}); end
  endtask

  task automatic test_basic_flush();
    logic [7:0] want[3];
    want = '{8'h12, 8'h34, 8'h56};
    do_reset();
    send(9'h012, 1'b0);
    send(9'h034, 1'b0);
    do_flush();
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL basic_flush_done got %0d required 1", fd_cnt); end
    // Flush in IDLE only pulses flush_done.
    do_flush();
    checks++; if (fd_cnt !== 2 || got_q.size() !== 2) begin errors++; $display("FAIL idle_flush fd=%0d bytes=%0d required 2 2", fd_cnt, got_q.size()); end
    // in_valid together with flush: the byte wins, no flush_done.
    send(9'h056, 1'b1);
    repeat (3) begin @(posedge general_clk); #1; end
    checks++; if (fd_cnt !== 2) begin errors++; $display("FAIL valid_flush_priority fd=%0d required 2", fd_cnt); end
    do_flush();
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL basic_count got %0d required 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== want[i]) begin errors++; $display("FAIL basic_byte[%0d] got %02h required %02h", i, got_q[i], want[i]); end
    end
  endtask

  task automatic test_carry_ripple();
    logic [7:0] want[4];
    want = '{8'h81, 8'h00, 8'h00, 8'h05};
    do_reset();
    send(9'h080, 1'b0);
    send(9'h0FF, 1'b0);
    send(9'h0FF, 1'b0);
    send(9'h105, 1'b0);
    repeat (6) begin @(posedge general_clk); #1; end
    checks++; if (got_q.size() !== 3 || in_ready !== 1'b1) begin errors++; $display("FAIL ripple_pre_flush bytes=%0d in_ready=%0b required 3 1", got_q.size(), in_ready); end
    do_flush();
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL ripple_count got %0d required 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== want[i]) begin errors++; $display("FAIL ripple_byte[%0d] got %02h required %02h", i, got_q[i], want[i]); end
    end
  endtask

  task automatic test_no_carry();
    logic [7:0] want[4];
    int n;
    want = '{8'h80, 8'hFF, 8'hFF, 8'h05};
    do_reset();
    send(9'h080, 1'b0);
    send(9'h0FF, 1'b0);
    send(9'h0FF, 1'b0);
    send(9'h005, 1'b0);
    n = 0;
    @(negedge general_clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge general_clk);
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL nocarry_in_ready_low got %0d cycles required 3", n); end
    @(posedge general_clk);
    #1;
    do_flush();
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL nocarry_count got %0d required 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== want[i]) begin errors++; $display("FAIL nocarry_byte[%0d] got %02h required %02h", i, got_q[i], want[i]); end
    end
  endtask

  task automatic setup_run3_stalled();
    rdy_mode = 2;
    out_ready = 1'b0;
    send(9'h080, 1'b0);
    send(9'h0FF, 1'b0);
    send(9'h0FF, 1'b0);
    send(9'h0FF, 1'b0);
    send(9'h005, 1'b0);
    out_ready = 1'b1;
    @(posedge general_clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] want[5];
    int bad;
    want = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h05};
    do_reset();
    setup_run3_stalled();
    bad = 0;
    repeat (5) begin
      @(posedge general_clk);
      #1;
      if (out_valid !== 1'b1 || out_byte !== 8'hFF) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_stable got %0d unstable cycles required 0", bad); end
    rdy_mode = 0;
    do_flush();
    checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL stall_count got %0d required 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== want[i]) begin errors++; $display("FAIL stall_byte[%0d] got %02h required %02h", i, got_q[i], want[i]); end
    end
  endtask

  task automatic test_orphan_overflow();
    int bad;
    do_reset();
    send(9'h1AA, 1'b0);
    checks++; if (err_orphan_carry !== 1'b1) begin errors++; $display("FAIL orphan_flag got %0b required 1", err_orphan_carry); end
    repeat (255) send(9'h0FF, 1'b0);
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL overflow_early got %0b required 0", err_overflow); end
    send(9'h0FF, 1'b0);
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag got %0b required 1", err_overflow); end
    do_flush();
    checks++; if (got_q.size() !== 256) begin errors++; $display("FAIL overflow_count got %0d required 256", got_q.size()); end
    checks++; if (got_q.size() > 0 && got_q[0] !== 8'hAA) begin errors++; $display("FAIL orphan_p got %02h required aa", got_q[0]); end
    bad = 0;
    for (int i = 1; i < got_q.size(); i++) if (got_q[i] !== 8'hFF) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL overflow_run got %0d non-ff bytes required 0", bad); end
    checks++; if ({err_overflow, err_orphan_carry} !== 2'b11) begin errors++; $display("FAIL errs_sticky got %02b required 11", {err_overflow, err_orphan_carry}); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    setup_run3_stalled();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %0b required 0", out_valid); end
    rdy_mode = 0;
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %0b required 1", in_ready); end
    repeat (5) begin @(posedge general_clk); #1; end
    checks++; if (got_q.size() !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_output bytes=%0d out_valid=%0b required 0 0", got_q.size(), out_valid); end
  endtask

  task automatic test_random();
    int r;
    logic [8:0] b;
    do_reset();
    rdy_mode = 1;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        do_flush();
      end else begin
        if (r < 45) b = 9'h0FF;
        else b = {($urandom_range(0, 4) == 0), 8'($urandom)};
        send(b, (r < 8));
      end
    end
    do_flush();
    rdy_mode = 0;
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_byte[%0d] got %02h required %02h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fd_cnt !== exp_fd) begin errors++; $display("FAIL random_flush_done got %0d required %0d", fd_cnt, exp_fd); end
    checks++; if (err_orphan_carry !== m_orph || err_overflow !== m_ovf) begin errors++; $display("FAIL random_errs got %0b%0b required %0b%0b", err_overflow, err_orphan_carry, m_ovf, m_orph); end
  endtask

  initial begin
    test_reset();
    test_basic_flush();
    test_carry_ripple();
    test_no_carry();
    test_backpressure();
    test_orphan_overflow();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
